alu_wb_stage: RTL

ALU_WB_STAGE -- requirements
Module: alu_wb_stage

---
 rtl/alu_wb_stage_pkg.sv | 54 +++++
 rtl/alu_wb_stage_cond_eval.sv | 50 +++++
 rtl/alu_wb_stage.sv | 92 +++++++++
 3 files changed

// File: rtl/alu_wb_stage_pkg.sv
// +----------------------------------------------------------------------------+
// | alu_wb_stage_pkg : opcode, condition-code and flag-index definitions       |
// | shared by the ALU and its writeback stage.                 Revision: 1.0   |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_wb_stage_pkg;

  typedef logic [2:0] alu_op_t;
  typedef logic [3:0] cond_t;

  localparam alu_op_t c_op_add = 3'b000;
  localparam alu_op_t c_op_sub = 3'b001;
  localparam alu_op_t c_op_rsb = 3'b010;
  localparam alu_op_t c_op_and = 3'b011;
  localparam alu_op_t c_op_not = 3'b100;
  localparam alu_op_t c_op_tst = 3'b101;
  localparam alu_op_t c_op_cmp = 3'b110;
  localparam alu_op_t c_op_mov = 3'b111;

  localparam cond_t c_cond_eq = 4'b0000;
  localparam cond_t c_cond_ne = 4'b0001;
  localparam cond_t c_cond_cs = 4'b0010;
  localparam cond_t c_cond_cc = 4'b0011;
  localparam cond_t c_cond_mi = 4'b0100;
  localparam cond_t c_cond_pl = 4'b0101;
  localparam cond_t c_cond_vs = 4'b0110;
  localparam cond_t c_cond_vc = 4'b0111;
  localparam cond_t c_cond_hi = 4'b1000;
  localparam cond_t c_cond_ls = 4'b1001;
  localparam cond_t c_cond_ge = 4'b1010;
  localparam cond_t c_cond_lt = 4'b1011;
  localparam cond_t c_cond_gt = 4'b1100;
  localparam cond_t c_cond_le = 4'b1101;
  localparam cond_t c_cond_al = 4'b1110;
  localparam cond_t c_cond_nv = 4'b1111;

  localparam int c_flag_z = 0;
  localparam int c_flag_c = 1;
  localparam int c_flag_n = 2;
  localparam int c_flag_v = 3;

  // Compare-type ops exist only for their flags and never touch the register file.
  function automatic logic op_writes_reg(input alu_op_t op);
    return (op != c_op_tst) && (op != c_op_cmp);
  endfunction

  function automatic logic op_writes_flags(input alu_op_t op, input logic set_flags);
    return set_flags || (op == c_op_tst) || (op == c_op_cmp);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_wb_stage_cond_eval.sv
// +----------------------------------------------------------------------------+
// | cond_eval : combinational ARM condition-code check against ZCNV status.    |
// |                                                            Revision: 1.0   |
// +----------------------------------------------------------------------------+
`default_nettype none

module cond_eval
  import alu_wb_stage_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] status,
  output logic       pass
);

  logic w_z;
  logic w_c;
  logic w_n;
  logic w_v;

  assign w_z = status[c_flag_z];
  assign w_c = status[c_flag_c];
  assign w_n = status[c_flag_n];
  assign w_v = status[c_flag_v];

  always_comb begin
    pass = 1'b0;
    case (cond)
      c_cond_eq: pass = w_z;
      c_cond_ne: pass = !w_z;
      c_cond_cs: pass = w_c;
      c_cond_cc: pass = !w_c;
      c_cond_mi: pass = w_n;
      c_cond_pl: pass = !w_n;
      c_cond_vs: pass = w_v;
      c_cond_vc: pass = !w_v;
      c_cond_hi: pass = w_c && !w_z;
      c_cond_ls: pass = !w_c || w_z;
      c_cond_ge: pass = (w_n == w_v);
      c_cond_lt: pass = (w_n != w_v);
      c_cond_gt: pass = !w_z && (w_n == w_v);
      c_cond_le: pass = w_z || (w_n != w_v);
      c_cond_al: pass = 1'b1;
      c_cond_nv: pass = 1'b0;
      default:   pass = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_wb_stage.sv
// +----------------------------------------------------------------------------+
// | alu_wb_stage : single-entry writeback register with conditional execution, |
// | committed ZCNV status and retire counter.                  Revision: 1.0   |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_wb_stage
  import alu_wb_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [3:0]    cond,
  input  logic          set_flags,
  input  logic [RW-1:0] rd,
  input  logic [DW-1:0] alu_result,
  input  logic [3:0]    alu_flag,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          wb_en,
  output logic [RW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic [3:0]    status,
  output logic [CW-1:0] retired
);

  logic          w_accept;
  logic          w_pass;
  logic          r_out_valid;
  logic          r_wb_en;
  logic [RW-1:0] r_wb_addr;
  logic [DW-1:0] r_wb_data;
  logic [3:0]    r_status;
  logic [CW-1:0] r_retired;

  // Condition is judged against committed status; a flag update from the
  // previous accept is already in r_status, so no bypass path is needed.
  cond_eval u_cond_eval (
    .cond   (cond),
    .status (r_status),
    .pass   (w_pass)
  );

  assign in_ready = (!r_out_valid || out_ready) && !flush;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_wb_en     <= 1'b0;
      r_wb_addr   <= '0;
      r_wb_data   <= '0;
      r_status    <= 4'b0000;
      r_retired   <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_wb_en     <= 1'b0;
    end else if (w_accept) begin
      // Failed-condition instructions still occupy the slot to keep ordering.
      r_out_valid <= 1'b1;
      r_wb_en     <= w_pass && op_writes_reg(op);
      r_wb_addr   <= rd;
      r_wb_data   <= alu_result;
      if (w_pass && op_writes_flags(op, set_flags)) begin
        r_status <= alu_flag;
      end
      if (w_pass) begin
        r_retired <= r_retired + CW'(1);
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_wb_en     <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign wb_en     = r_wb_en && r_out_valid;
  assign wb_addr   = r_wb_addr;
  assign wb_data   = r_wb_data;
  assign status    = r_status;
  assign retired   = r_retired;

endmodule

`default_nettype wire
